// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_data_tx between an echo port (0) and a
// status port (1); latches the winning frame, pulses send_en and acks on Tx_Done or timeout.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  send_en,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             pick;

    // On contention the port that did not win last time is served.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) pick = ~last_grant;
        else              pick = req1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            tx_data    <= '0;
            send_en    <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            err        <= 1'b0;
        end else begin
            send_en <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        tx_data    <= pick ? data1 : data0;
                        grant_id   <= pick;
                        last_grant <= pick;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    send_en <= 1'b1;
                    cnt     <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    // tx_done wins over a timeout landing on the same cycle
                    if (tx_done || (cnt == CNT_LAST)) begin
                        ack0  <= ~grant_id;
                        ack1  <= grant_id;
                        err   <= ~tx_done;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle-by-cycle vector table plus
// hand-written sequences for round-robin, timeout boundary and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n, req0, req1, tx_done;
    logic [31:0] data0, data1, tx_data;
    logic        ack0, ack1, send_en, busy, grant_id, err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYC(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .tx_data(tx_data), .send_en(send_en), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id), .err(err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst_n;
        logic        r0;
        logic [31:0] d0;
        logic        r1;
        logic [31:0] d1;
        logic        done;
        logic        busy;
        logic        send;
        logic        a0;
        logic        a1;
        logic        gid;
        logic        err;
        logic [31:0] txd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return busy;
            1:       return send_en;
            default: return ack0 | ack1;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int maxc, input string name);
        for (int n = 0; n < maxc; n++) begin
            cyc();
            if (sig(sel) === 1'b1) return;
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // One frame on a port whose req stays high; bench supplies tx_done.
    task automatic serve(input logic exp_gid, input logic [31:0] exp_txd, input string tag);
        wait_until(0, 10, {tag, "_busy"});
        chk({tag, "_gid"}, 32'(grant_id), 32'(exp_gid));
        chk({tag, "_txd"}, tx_data, exp_txd);
        wait_until(1, 5, {tag, "_send"});
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk({tag, "_ack0"}, 32'(ack0), 32'(!exp_gid));
        chk({tag, "_ack1"}, 32'(ack1), 32'(exp_gid));
        chk({tag, "_err"}, 32'(err), 32'd0);
        cyc();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        //            rst r0 d0            r1 d1            dn  bsy snd a0 a1 gid err txd
        vecs[0]  = '{1, 1, 32'hDEADBEEF, 0, 32'h0,        0,  1,  0,  0, 0, 0,  0, 32'hDEADBEEF};
        vecs[1]  = '{1, 1, 32'hDEADBEEF, 0, 32'h0,        1,  1,  1,  0, 0, 0,  0, 32'hDEADBEEF};
        vecs[2]  = '{1, 1, 32'hDEADBEEF, 0, 32'h0,        0,  1,  0,  0, 0, 0,  0, 32'hDEADBEEF};
        vecs[3]  = '{1, 1, 32'hDEADBEEF, 0, 32'h0,        1,  1,  0,  1, 0, 0,  0, 32'hDEADBEEF};
        vecs[4]  = '{1, 0, 32'hDEADBEEF, 0, 32'h0,        0,  0,  0,  0, 0, 0,  0, 32'hDEADBEEF};
        vecs[5]  = '{0, 0, 32'h0,        0, 32'h0,        0,  0,  0,  0, 0, 0,  0, 32'h0};
        vecs[6]  = '{1, 1, 32'h11111111, 1, 32'h22222222, 0,  1,  0,  0, 0, 0,  0, 32'h11111111};
        vecs[7]  = '{1, 1, 32'h11111111, 1, 32'h22222222, 0,  1,  1,  0, 0, 0,  0, 32'h11111111};
        vecs[8]  = '{1, 1, 32'h11111111, 1, 32'h22222222, 1,  1,  0,  1, 0, 0,  0, 32'h11111111};
        vecs[9]  = '{1, 0, 32'h11111111, 1, 32'h22222222, 0,  0,  0,  0, 0, 0,  0, 32'h11111111};
        vecs[10] = '{1, 0, 32'h11111111, 1, 32'h22222222, 0,  1,  0,  0, 0, 1,  0, 32'h22222222};
        vecs[11] = '{1, 1, 32'h44444444, 1, 32'h55555555, 0,  1,  1,  0, 0, 1,  0, 32'h22222222};
        vecs[12] = '{1, 1, 32'h44444444, 1, 32'h55555555, 1,  1,  0,  0, 1, 1,  0, 32'h22222222};
        vecs[13] = '{1, 1, 32'h44444444, 0, 32'h55555555, 0,  0,  0,  0, 0, 1,  0, 32'h22222222};
        vecs[14] = '{1, 1, 32'h44444444, 0, 32'h55555555, 0,  1,  0,  0, 0, 0,  0, 32'h44444444};

        Rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; tx_done = 1'b0;
        data0 = '0; data1 = '0;
        repeat (3) cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_send", 32'(send_en), 32'd0);
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);
        chk("rst_gid_err", 32'({grant_id, err}), 32'd0);
        chk("rst_txd", tx_data, 32'd0);

        for (int i = 0; i < 15; i++) begin
            Rst_n = vecs[i].rst_n; req0 = vecs[i].r0; data0 = vecs[i].d0;
            req1 = vecs[i].r1; data1 = vecs[i].d1; tx_done = vecs[i].done;
            cyc();
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_send", i), 32'(send_en), 32'(vecs[i].send));
            chk($sformatf("v%0d_ack0", i), 32'(ack0), 32'(vecs[i].a0));
            chk($sformatf("v%0d_ack1", i), 32'(ack1), 32'(vecs[i].a1));
            chk($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vecs[i].gid));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("v%0d_txd", i), tx_data, vecs[i].txd);
        end
        req0 = 1'b0; req1 = 1'b0; tx_done = 1'b0;

        // Round-robin with both ports continuously requesting
        Rst_n = 1'b0; cyc(); Rst_n = 1'b1;
        req0 = 1'b1; data0 = 32'hA0A0A0A0;
        req1 = 1'b1; data1 = 32'hB1B1B1B1;
        serve(1'b0, 32'hA0A0A0A0, "rr0");
        serve(1'b1, 32'hB1B1B1B1, "rr1");
        serve(1'b0, 32'hA0A0A0A0, "rr2");
        serve(1'b1, 32'hB1B1B1B1, "rr3");
        req0 = 1'b0; req1 = 1'b0;
        cyc(); cyc();

        // Timeout: no tx_done, WAIT must last exactly 16 cycles
        req0 = 1'b1; data0 = 32'h0BADF00D;
        wait_until(1, 5, "to_send");
        n = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            n++;
            if (ack0 === 1'b1) break;
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_ack0", 32'(ack0), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        req0 = 1'b0;
        cyc();
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_idle_err", 32'(err), 32'd0);
        cyc();

        // tx_done arriving on the final counter value beats the timeout
        req0 = 1'b1; data0 = 32'h12345678;
        wait_until(1, 5, "edge_send");
        for (int k = 0; k < 15; k++) cyc();
        chk("edge_no_early_ack", 32'(ack0), 32'd0);
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk("edge_ack0", 32'(ack0), 32'd1);
        chk("edge_err", 32'(err), 32'd0);
        req0 = 1'b0;
        cyc(); cyc();

        // Asynchronous reset in the middle of WAIT
        req0 = 1'b1; data0 = 32'h77777777;
        wait_until(1, 5, "ar_send");
        repeat (3) cyc();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_send", 32'(send_en), 32'd0);
        chk("ar_ack", 32'({ack1, ack0}), 32'd0);
        chk("ar_gid_err", 32'({grant_id, err}), 32'd0);
        chk("ar_txd", tx_data, 32'd0);
        req0 = 1'b0; req1 = 1'b1; data1 = 32'hCAFEF00D;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("ar_no_ack", 32'({ack1, ack0, err}), 32'd0);
        end
        Rst_n = 1'b1;
        serve(1'b1, 32'hCAFEF00D, "ar_p1");
        req1 = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
